// File: rtl/pulse_transmitter_symbol_sequencer.sv
// Symbol sequencer feeding pulse_transmitter_countdown_timer: walks packed 2-bit
// symbols, presents per-symbol timing to the timer and drives the pin level.
module pulse_transmitter_symbol_sequencer #(
   parameter int PRESCALER_WIDTH = 15,
   parameter int TIMER_WIDTH     = 8,
   parameter int NUM_SYMBOLS     = 16,
   localparam int PW             = $clog2(PRESCALER_WIDTH + 1),
   localparam int IW             = $clog2(NUM_SYMBOLS)
) (
   input  logic                     clk,
   input  logic                     sys_rst_n,
   input  logic                     start,
   input  logic                     stop,
   input  logic [2*NUM_SYMBOLS-1:0] symbol_data,
   input  logic [IW-1:0]            symbol_last,
   input  logic [7:0]               loop_count,
   input  logic                     idle_level,
   input  logic [PW-1:0]            prescaler_a,
   input  logic [PW-1:0]            prescaler_b,
   input  logic [TIMER_WIDTH-1:0]   duration_a,
   input  logic [TIMER_WIDTH-1:0]   duration_b,
   input  logic                     timer_pulse,
   output logic                     timer_en,
   output logic [PW-1:0]            timer_prescaler,
   output logic [TIMER_WIDTH-1:0]   timer_duration,
   output logic                     pin_out,
   output logic                     busy,
   output logic                     done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t                   state_reg;
   logic [2*NUM_SYMBOLS-1:0] data_reg;
   logic [IW-1:0]            last_reg;
   logic [IW-1:0]            index_reg;
   logic [7:0]               loops_reg;

   logic [1:0]    sym_arr [NUM_SYMBOLS];
   logic [IW-1:0] index_next;
   logic [1:0]    sym_next;
   logic [1:0]    sym_first;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SYMBOLS; gi++) begin : g_sym
         assign sym_arr[gi] = data_reg[2*gi +: 2];
      end
   endgenerate

   // index_next is only used when index_reg < last_reg, so it never wraps.
   assign index_next = index_reg + IW'(1);
   assign sym_next   = sym_arr[index_next];
   assign sym_first  = sym_arr[0];

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg       <= ST_IDLE;
         data_reg        <= '0;
         last_reg        <= '0;
         index_reg       <= '0;
         loops_reg       <= '0;
         timer_en        <= 1'b0;
         timer_prescaler <= '0;
         timer_duration  <= '0;
         pin_out         <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               pin_out  <= idle_level;
               timer_en <= 1'b0;
               busy     <= 1'b0;
               if (start && !stop) begin
                  data_reg        <= symbol_data;
                  last_reg        <= symbol_last;
                  loops_reg       <= loop_count;
                  index_reg       <= '0;
                  // Timing goes out a cycle ahead of timer_en, as the timer requires.
                  timer_prescaler <= symbol_data[0] ? prescaler_b : prescaler_a;
                  timer_duration  <= symbol_data[0] ? duration_b : duration_a;
                  busy            <= 1'b1;
                  state_reg       <= ST_ARM;
               end
            end

            ST_ARM: begin
               if (stop) begin
                  timer_en  <= 1'b0;
                  pin_out   <= idle_level;
                  busy      <= 1'b0;
                  state_reg <= ST_IDLE;
               end else begin
                  timer_en  <= 1'b1;
                  pin_out   <= sym_first[1];
                  state_reg <= ST_RUN;
               end
            end

            ST_RUN: begin
               if (stop) begin
                  timer_en  <= 1'b0;
                  pin_out   <= idle_level;
                  busy      <= 1'b0;
                  state_reg <= ST_IDLE;
               end else if (timer_pulse) begin
                  if (index_reg < last_reg) begin
                     index_reg       <= index_next;
                     pin_out         <= sym_next[1];
                     timer_prescaler <= sym_next[0] ? prescaler_b : prescaler_a;
                     timer_duration  <= sym_next[0] ? duration_b : duration_a;
                  end else if (loops_reg != 8'd0) begin
                     loops_reg       <= loops_reg - 8'd1;
                     index_reg       <= '0;
                     pin_out         <= sym_first[1];
                     timer_prescaler <= sym_first[0] ? prescaler_b : prescaler_a;
                     timer_duration  <= sym_first[0] ? duration_b : duration_a;
                  end else begin
                     timer_en  <= 1'b0;
                     pin_out   <= idle_level;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state_reg <= ST_DONE;
                  end
               end
            end

            ST_DONE: begin
               pin_out   <= idle_level;
               state_reg <= ST_IDLE;
            end

            default: begin
               timer_en  <= 1'b0;
               busy      <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_transmitter_symbol_sequencer.sv
// Bench for pulse_transmitter_symbol_sequencer: vector table, hand sequences and
// randomized traffic against a queue-based reference model.
module tb_pulse_transmitter_symbol_sequencer;

   localparam int PW = 4;
   localparam int TW = 8;
   localparam int NS = 16;
   localparam int IW = 4;

   logic            clk = 1'b0;
   logic            sys_rst_n = 1'b0;
   logic            start = 1'b0;
   logic            stop = 1'b0;
   logic [2*NS-1:0] symbol_data = '0;
   logic [IW-1:0]   symbol_last = '0;
   logic [7:0]      loop_count = '0;
   logic            idle_level = 1'b0;
   logic [PW-1:0]   prescaler_a = '0;
   logic [PW-1:0]   prescaler_b = '0;
   logic [TW-1:0]   duration_a = '0;
   logic [TW-1:0]   duration_b = '0;
   logic            timer_pulse = 1'b0;
   logic            timer_en;
   logic [PW-1:0]   timer_prescaler;
   logic [TW-1:0]   timer_duration;
   logic            pin_out;
   logic            busy;
   logic            done;

   pulse_transmitter_symbol_sequencer #(
      .PRESCALER_WIDTH(15),
      .TIMER_WIDTH    (TW),
      .NUM_SYMBOLS    (NS)
   ) dut (
      .clk            (clk),
      .sys_rst_n      (sys_rst_n),
      .start          (start),
      .stop           (stop),
      .symbol_data    (symbol_data),
      .symbol_last    (symbol_last),
      .loop_count     (loop_count),
      .idle_level     (idle_level),
      .prescaler_a    (prescaler_a),
      .prescaler_b    (prescaler_b),
      .duration_a     (duration_a),
      .duration_b     (duration_b),
      .timer_pulse    (timer_pulse),
      .timer_en       (timer_en),
      .timer_prescaler(timer_prescaler),
      .timer_duration (timer_duration),
      .pin_out        (pin_out),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: the run is the flat list of symbols still to emit.
   int            m_phase;  // 0 idle, 1 arm, 2 run, 3 done
   logic [1:0]    m_q[$];
   logic          m_en, m_pin, m_busy, m_done;
   logic [PW-1:0] m_psc;
   logic [TW-1:0] m_dur;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_q.delete();
      m_en = 0; m_pin = 0; m_busy = 0; m_done = 0; m_psc = '0; m_dur = '0;
   endtask

   task automatic model_load(input logic [1:0] s);
      m_psc = s[0] ? prescaler_b : prescaler_a;
      m_dur = s[0] ? duration_b : duration_a;
      m_pin = s[1];
   endtask

   task automatic model_abort();
      m_en = 0; m_pin = idle_level; m_busy = 0; m_phase = 0;
   endtask

   task automatic model_step();
      m_done = 0;
      case (m_phase)
         0: begin
            m_pin = idle_level;
            if (start && !stop) begin
               m_q.delete();
               for (int p = 0; p <= int'(loop_count); p++)
                  for (int k = 0; k <= int'(symbol_last); k++)
                     m_q.push_back(symbol_data[2*k +: 2]);
               model_load(m_q[0]);
               m_pin = idle_level;
               m_busy = 1;
               m_phase = 1;
            end
         end
         1: begin
            if (stop) model_abort();
            else begin
               m_en = 1; m_pin = m_q[0][1]; m_phase = 2;
            end
         end
         2: begin
            if (stop) model_abort();
            else if (timer_pulse) begin
               void'(m_q.pop_front());
               if (m_q.size() > 0) model_load(m_q[0]);
               else begin
                  m_en = 0; m_pin = idle_level; m_busy = 0; m_done = 1; m_phase = 3;
               end
            end
         end
         default: begin
            m_pin = idle_level;
            m_phase = 0;
         end
      endcase
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      chk("model_timer_en", timer_en, m_en);
      chk("model_prescaler", timer_prescaler, m_psc);
      chk("model_duration", timer_duration, m_dur);
      chk("model_pin_out", pin_out, m_pin);
      chk("model_busy", busy, m_busy);
      chk("model_done", done, m_done);
   endtask

   typedef struct {
      logic          start, stop, pulse;
      logic          en, pin, busy, done;
      logic [PW-1:0] psc;
      logic [TW-1:0] dur;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int pulses, done_cnt, toggles, c;
      logic prev_pin, aborted;

      // Basic pass: {1/A, 0/B, 1/A}, A=(0,3), B=(1,2), idle 0.
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd3};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8'd3};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8'd3};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 8'd2};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 8'd2};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8'd3};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 8'd3};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd3};
      tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd3};

      model_reset();
      idle_level = 1'b1;
      #1;
      chk("reset_timer_en", timer_en, 0);
      chk("reset_prescaler", timer_prescaler, 0);
      chk("reset_duration", timer_duration, 0);
      chk("reset_pin_out", pin_out, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      @(negedge clk); @(negedge clk);
      sys_rst_n = 1'b1;
      cycle();
      chk("idle_follows_level", pin_out, 1);
      idle_level = 1'b0;
      cycle();

      symbol_data = 32'h0000_0026; symbol_last = 4'd2; loop_count = 8'd0;
      prescaler_a = 4'd0; duration_a = 8'd3; prescaler_b = 4'd1; duration_b = 8'd2;
      for (int i = 0; i < 9; i++) begin
         start = tbl[i].start; stop = tbl[i].stop; timer_pulse = tbl[i].pulse;
         cycle();
         chk($sformatf("tbl%0d_en", i), timer_en, tbl[i].en);
         chk($sformatf("tbl%0d_pin", i), pin_out, tbl[i].pin);
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
         chk($sformatf("tbl%0d_done", i), done, tbl[i].done);
         chk($sformatf("tbl%0d_psc", i), timer_prescaler, tbl[i].psc);
         chk($sformatf("tbl%0d_dur", i), timer_duration, tbl[i].dur);
      end
      start = 0; timer_pulse = 0;

      // Repeat: one symbol (1/B), three extra passes.
      symbol_data = 32'h0000_0003; symbol_last = 4'd0; loop_count = 8'd3;
      start = 1; cycle(); start = 0;
      pulses = 0; done_cnt = 0;
      for (int i = 0; i < 100 && done_cnt == 0; i++) begin
         timer_pulse = timer_en && (i % 3 == 2);
         if (timer_pulse) pulses++;
         cycle();
         done_cnt += int'(done);
      end
      timer_pulse = 0;
      for (int i = 0; i < 4; i++) begin cycle(); done_cnt += int'(done); end
      chk("repeat_pulses", pulses, 4);
      chk("repeat_done_count", done_cnt, 1);

      // Full word, alternating levels; a second start with other data is ignored.
      symbol_data = 32'h2222_2222; symbol_last = 4'd15; loop_count = 8'd0;
      start = 1; cycle(); start = 0;
      prev_pin = pin_out; toggles = 0; pulses = 0; done_cnt = 0;
      for (int i = 0; i < 200 && done_cnt == 0; i++) begin
         timer_pulse = timer_en && (i % 2 == 1);
         if (timer_pulse) pulses++;
         if (i == 5) begin start = 1; symbol_data = 32'h0; symbol_last = 4'd1; end
         cycle();
         start = 0;
         if (pin_out != prev_pin) toggles++;
         prev_pin = pin_out;
         done_cnt += int'(done);
      end
      timer_pulse = 0;
      chk("fullword_toggles", toggles, 16);
      chk("fullword_pulses", pulses, 16);
      chk("fullword_done", done_cnt, 1);
      cycle();

      // Abort on the second timer pulse.
      symbol_data = 32'h0000_0026; symbol_last = 4'd2; loop_count = 8'd1; idle_level = 1'b1;
      start = 1; cycle(); start = 0;
      pulses = 0; done_cnt = 0; aborted = 0; c = 0;
      for (int i = 0; i < 40; i++) begin
         timer_pulse = timer_en && (i % 3 == 2);
         stop = timer_pulse && (pulses == 1);
         if (timer_pulse) pulses++;
         cycle();
         if (stop) begin
            aborted = 1;
            chk("abort_timer_en", timer_en, 0);
            chk("abort_pin_idle", pin_out, 1);
            chk("abort_busy", busy, 0);
         end
         stop = 0;
         done_cnt += int'(done);
      end
      timer_pulse = 0;
      chk("abort_happened", aborted, 1);
      chk("abort_no_done", done_cnt, 0);
      idle_level = 1'b0;

      // Asynchronous reset mid-run clears outputs before any clock edge.
      symbol_data = 32'h0000_00B6; symbol_last = 4'd3; loop_count = 8'd2;
      start = 1; cycle(); start = 0;
      for (int i = 0; i < 6; i++) begin timer_pulse = (i == 3); cycle(); end
      timer_pulse = 0;
      chk("pre_reset_busy", busy, 1);
      sys_rst_n = 1'b0;
      #2;
      chk("async_rst_timer_en", timer_en, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_pin", pin_out, 0);
      @(negedge clk); @(negedge clk);
      sys_rst_n = 1'b1;
      model_reset();
      cycle();

      // Timing handshake: prescaler/duration valid a cycle before timer_en.
      symbol_data = 32'h0000_0002; symbol_last = 4'd0; loop_count = 8'd0;
      prescaler_a = 4'd4; duration_a = 8'd0;
      start = 1; cycle(); start = 0;
      chk("hs_psc_early", timer_prescaler, 4);
      chk("hs_dur_early", timer_duration, 0);
      chk("hs_en_low", timer_en, 0);
      cycle();
      chk("hs_en_high", timer_en, 1);
      stop = 1; cycle(); stop = 0;
      cycle();

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         symbol_data = $urandom;
         symbol_last = IW'($urandom_range(0, 15));
         loop_count  = 8'($urandom_range(0, 3));
         start       = ($urandom_range(0, 5) == 0);
         stop        = ($urandom_range(0, 40) == 0);
         timer_pulse = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 7) == 0) idle_level = ~idle_level;
         if ($urandom_range(0, 15) == 0) begin
            prescaler_a = PW'($urandom); prescaler_b = PW'($urandom);
            duration_a  = TW'($urandom); duration_b  = TW'($urandom);
         end
         cycle();
      end
      start = 0; stop = 0; timer_pulse = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
